// File: rtl/apb4_regbank_slave.sv
// APB4 register bank slave: NUM_REGS word registers with byte strobes, optional
// read-only status registers, privilege filtering and programmable wait states.
module apb4_regbank_slave #(
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      ADDR_WIDTH  = 32,
  parameter int                      NUM_REGS    = 8,
  parameter int                      WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]     RO_MASK     = '0,
  parameter bit                      PRIV_ONLY   = 1'b0,
  parameter logic [DATA_WIDTH-1:0]   RESET_VAL   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic                           o_dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int SPAN   = NUM_REGS * STRB_W;

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  logic                  w_setup, w_done, w_wr_ok;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_misaligned, w_oor, w_ro_wr, w_priv_err, w_err;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused_prot;

  // Address decode is evaluated in the setup phase and frozen for the access phase.
  assign w_idx        = PADDR[OFF_W +: IDX_W];
  assign w_misaligned = |(PADDR & ADDR_WIDTH'(STRB_W - 1));
  assign w_oor        = {1'b0, PADDR} >= (ADDR_WIDTH + 1)'(SPAN);
  assign w_ro_wr      = PWRITE && RO_MASK[w_idx];
  assign w_priv_err   = PRIV_ONLY && !PPROT[0];
  assign w_err        = w_misaligned || w_oor || w_ro_wr || w_priv_err;
  assign w_unused_prot = ^PPROT[2:1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_setup     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = 4'(WAIT_STATES);
          w_setup     = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (PENABLE) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_setup) begin
        r_idx   <= w_idx;
        r_err   <= w_err;
        r_write <= PWRITE;
      end
    end
  end

  assign w_wr_ok = w_done && r_write && !r_err;

  // Write data and strobes are taken from the bus on the completion edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wr_ok ? (NUM_REGS'(1) << r_idx) : '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && (int'(r_idx) == i) && !RO_MASK[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (PSTRB[b]) r_regs[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  assign w_rd_val = RO_MASK[r_idx] ? status_in[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH]
                                   : r_regs[r_idx];

  always_comb begin
    PREADY  = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    PSLVERR = PREADY && r_err;
    PRDATA  = (PREADY && !r_write && !r_err) ? w_rd_val : '0;
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : r_regs[i];
    end
  end

  assign wr_pulse    = r_wr_pulse;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb4_regbank_slave.sv
// Directed bench for apb4_regbank_slave: three instances cover zero wait states
// with a read-only register, three wait states with privilege filtering, and
// two wait states for abort and mid-transfer reset.
module tb_apb4_regbank_slave;

  logic         clk;
  logic         rst_n;
  logic [2:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [255:0] status;

  logic         pready_w  [3];
  logic [31:0]  prdata_w  [3];
  logic         pslverr_w [3];
  logic [255:0] regq_w    [3];
  logic [7:0]   wrp_w     [3];
  logic         dbg_w     [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb4_regbank_slave #(
    .WAIT_STATES(0), .RO_MASK(8'h80), .PRIV_ONLY(1'b0), .RESET_VAL(32'h0000_0000)
  ) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready_w[0]), .PRDATA(prdata_w[0]), .PSLVERR(pslverr_w[0]),
    .status_in(status), .reg_q(regq_w[0]), .wr_pulse(wrp_w[0]), .o_dbg_state(dbg_w[0])
  );

  apb4_regbank_slave #(
    .WAIT_STATES(3), .RO_MASK(8'h00), .PRIV_ONLY(1'b1), .RESET_VAL(32'h1111_1111)
  ) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready_w[1]), .PRDATA(prdata_w[1]), .PSLVERR(pslverr_w[1]),
    .status_in(status), .reg_q(regq_w[1]), .wr_pulse(wrp_w[1]), .o_dbg_state(dbg_w[1])
  );

  apb4_regbank_slave #(
    .WAIT_STATES(2), .RO_MASK(8'h00), .PRIV_ONLY(1'b0), .RESET_VAL(32'h5A5A_5A5A)
  ) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready_w[2]), .PRDATA(prdata_w[2]), .PSLVERR(pslverr_w[2]),
    .status_in(status), .reg_q(regq_w[2]), .wr_pulse(wrp_w[2]), .o_dbg_state(dbg_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Setup phase is driven immediately; returns 1ns after the completion edge
  // with the bus still driven so a following call forms a back-to-back pair.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rdata, output logic err, output int waits);
    bit got;
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    rdata = '0;
    err   = 1'b0;
    got   = 1'b0;
    while (!got) begin
      @(negedge clk);
      if (pready_w[d]) begin
        rdata = prdata_w[d];
        err   = pslverr_w[d];
        got   = 1'b1;
      end else begin
        waits++;
        if (waits > 40) begin
          chk("xfer_timeout", 32'(pready_w[d]), 32'd1);
          got = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;

  initial begin
    rst_n   = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = 3'b001;
    status  = '0;
    status[7*32 +: 32] = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 32'(pready_w[0]), 32'd0);
    chk("rst_pslverr", 32'(pslverr_w[0]), 32'd0);
    chk("rst_prdata", prdata_w[0], 32'h0);
    chk("rst_reg1", regq_w[0][63:32], 32'h0);
    chk("rst_wrp", 32'(wrp_w[0]), 32'h0);
    chk("rst_state", 32'(dbg_w[0]), 32'd0);
    chk("rst_val_dut1", regq_w[1][31:0], 32'h1111_1111);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_idle();

    // zero-wait write and read
    xfer(0, 1'b1, 32'h4, 32'hA5A5_1234, 4'hF, 3'b001, rd, er, wt);
    chk("w1_err", 32'(er), 32'd0);
    chk("w1_waits", 32'(wt), 32'd0);
    chk("w1_pulse", 32'(wrp_w[0]), 32'h02);
    bus_idle();
    chk("w1_pulse_end", 32'(wrp_w[0]), 32'h00);
    chk("w1_regq", regq_w[0][63:32], 32'hA5A5_1234);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("r1_data", rd, 32'hA5A5_1234);
    chk("r1_err", 32'(er), 32'd0);
    chk("r1_waits", 32'(wt), 32'd0);
    bus_idle();

    // back-to-back writes then partial strobe readback
    xfer(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, er, wt);
    chk("b2b_pulse0", 32'(wrp_w[0]), 32'h04);
    xfer(0, 1'b1, 32'h8, 32'h0000_0000, 4'h5, 3'b001, rd, er, wt);
    chk("b2b_err", 32'(er), 32'd0);
    chk("b2b_waits", 32'(wt), 32'd0);
    chk("b2b_pulse1", 32'(wrp_w[0]), 32'h04);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("strb_data", rd, 32'hFF00_FF00);

    // empty strobe: no change, no error, pulse still fires
    xfer(0, 1'b1, 32'h8, 32'h1234_5678, 4'h0, 3'b001, rd, er, wt);
    chk("nostrb_err", 32'(er), 32'd0);
    chk("nostrb_pulse", 32'(wrp_w[0]), 32'h04);
    chk("nostrb_reg", regq_w[0][95:64], 32'hFF00_FF00);
    bus_idle();

    // error cases
    xfer(0, 1'b0, 32'h2, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("misal_err", 32'(er), 32'd1);
    chk("misal_data", rd, 32'h0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", rd, 32'h0);
    xfer(0, 1'b1, 32'h1C, 32'h1357_9BDF, 4'hF, 3'b001, rd, er, wt);
    chk("ro_wr_err", 32'(er), 32'd1);
    chk("ro_wr_pulse", 32'(wrp_w[0]), 32'h00);
    chk("ro_regq", regq_w[0][255:224], 32'h0);
    xfer(0, 1'b1, 32'h6, 32'h0, 4'hF, 3'b001, rd, er, wt);
    chk("misal_wr_err", 32'(er), 32'd1);
    chk("misal_wr_pulse", 32'(wrp_w[0]), 32'h00);
    chk("misal_wr_reg", regq_w[0][63:32], 32'hA5A5_1234);
    xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("ro_rd_err", 32'(er), 32'd0);
    chk("ro_rd_data", rd, 32'hCAFE_F00D);
    bus_idle();

    // three wait states with privilege checking
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("ws3_waits", 32'(wt), 32'd3);
    chk("ws3_data", rd, 32'h1111_1111);
    chk("ws3_err", 32'(er), 32'd0);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, wt);
    chk("priv_rd_err", 32'(er), 32'd1);
    chk("priv_rd_data", rd, 32'h0);
    chk("priv_rd_waits", 32'(wt), 32'd3);
    xfer(1, 1'b1, 32'h4, 32'h0, 4'hF, 3'b000, rd, er, wt);
    chk("priv_wr_err", 32'(er), 32'd1);
    chk("priv_wr_pulse", 32'(wrp_w[1]), 32'h00);
    chk("priv_wr_reg", regq_w[1][63:32], 32'h1111_1111);
    xfer(1, 1'b1, 32'hC, 32'hABCD_0000, 4'hC, 3'b001, rd, er, wt);
    chk("ws3_wr_err", 32'(er), 32'd0);
    chk("ws3_wr_pulse", 32'(wrp_w[1]), 32'h08);
    chk("ws3_wr_reg", regq_w[1][127:96], 32'hABCD_1111);
    bus_idle();

    // master abort in first access cycle
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h4;
    pwdata  = 32'h0;
    pstrb   = 4'hF;
    pprot   = 3'b001;
    @(posedge clk); #1;
    chk("abort_in_access", 32'(dbg_w[2]), 32'd1);
    psel    = 3'b000;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 32'(dbg_w[2]), 32'd0);
    chk("abort_pulse", 32'(wrp_w[2]), 32'h00);
    penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_reg", regq_w[2][63:32], 32'h5A5A_5A5A);

    xfer(2, 1'b1, 32'h8, 32'h0102_0304, 4'hF, 3'b001, rd, er, wt);
    chk("ws2_waits", 32'(wt), 32'd2);
    chk("ws2_reg", regq_w[2][95:64], 32'h0102_0304);
    bus_idle();

    // reset during a write access phase
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h8;
    pwdata  = 32'hFFFF_FFFF;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_reg2", regq_w[2][95:64], 32'h5A5A_5A5A);
    chk("mrst_pready", 32'(pready_w[2]), 32'd0);
    chk("mrst_state", 32'(dbg_w[2]), 32'd0);
    chk("mrst_dut0_reg1", regq_w[0][63:32], 32'h0);
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
    chk("mrst_hold_reg2", regq_w[2][95:64], 32'h5A5A_5A5A);
    rst_n = 1'b1;
    bus_idle();
    xfer(2, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, 3'b001, rd, er, wt);
    chk("post_rst_err", 32'(er), 32'd0);
    chk("post_rst_waits", 32'(wt), 32'd2);
    chk("post_rst_pulse", 32'(wrp_w[2]), 32'h04);
    xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, rd, er, wt);
    chk("post_rst_rd", rd, 32'h0BAD_F00D);
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
